posicionador_de_navios: RTL and testbench
=========================================

Name: posicionador_de_navios

Overview:
Map-writer counterpart of the attack manager. Player steers a cursor over the 5-column x 7-row grid, picks an orientation and confirms, placing a fixed fleet ship by ship. The block validates each placement (bounds, overlap) and builds the final map mapa0..mapa4 consumed by the attack stage. It also drives a live preview for the LED matrix and status LEDs.

Parameters:
TAM_NAVIO0, 3, length of first ship placed (cells)
TAM_NAVIO1, 2, length of second ship
TAM_NAVIO2, 1, length of third ship

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears everything
enable  input  1  placement session active; low clears map and returns to idle
coordColuna  input  3  cursor column (valid 0..4)
coordLinha  input  3  cursor row (valid 0..6)
orientacao  input  1  0 = horizontal (grows toward higher column), 1 = vertical (grows toward higher row)
confirmar  input  1  level button; rising edge detected internally
mapa0..mapa4  output  7 each  committed map; mapaN = column N, bit k = row k
previa0..previa4  output  7 each  committed map OR in-bounds cells of current ghost ship
navio_atual  output  2  index of ship being placed (0..2; 3 when complete)
valido  output  1  combinational: current ghost is in bounds and overlap-free
LED_R  output  1  last confirm rejected
LED_G  output  1  last confirm accepted
mapa_pronto  output  1  all ships placed, map frozen

Behaviour:
- Reset (synchronous, high): mapa*=0, navio_atual=0, LED_R=LED_G=0, mapa_pronto=0, state OCIOSO, conf_prev=0. Reset wins over every other event.
- Edge detect: conf_prev registers confirmar each cycle; pulso = confirmar & ~conf_prev. A held button yields exactly one pulso.
- States: OCIOSO, POSICIONA, PRONTO.
- OCIOSO: outputs as reset; when enable=1 -> POSICIONA next cycle with navio_atual=0.
- enable=0 in any state -> next edge: mapa*=0, navio_atual=0, LEDs=0, mapa_pronto=0, state OCIOSO.
- POSICIONA: ghost mask = TAM cells from (coordColuna, coordLinha) along orientacao, with TAM selected by navio_atual. valido=0 if the start coordinate is out of range (col>4 or row>6), the end cell exceeds col 4 / row 6, or any cell intersects the committed map.
- On pulso with valido=1: mapa |= mask, navio_atual+1, LED_G=1, LED_R=0; if navio_atual was 2 -> PRONTO, mapa_pronto=1. Visible after the same edge (latency 1 cycle from pulso).
- On pulso with valido=0: map unchanged, LED_R=1, LED_G=0; state and navio_atual unchanged.
- LED_R/LED_G hold until the next pulso, enable=0 or reset.
- PRONTO: pulso ignored; mapa*, LEDs held; navio_atual=3; valido=0; previa = mapa.
- previa is combinational from registered map and current inputs; in OCIOSO it is 0. Out-of-bounds ghost cells are clipped, never wrapped.
- Overlap only; adjacency is allowed.
- pulso and enable falling in the same cycle: the clear takes priority.

Decomposition:
- Shared package: NUM_COLUNAS=5, NUM_LINHAS=7, state encoding (OCIOSO, POSICIONA, PRONTO), default ship lengths, NUM_NAVIOS=3.
- One combinational sub-module, gerador_mascara_navio: inputs are col, row, orientacao and size; outputs are a 35-bit mask (five 7-bit columns) and fora_limites. The top block holds the FSM, the edge detector, the map registers and the LEDs.

Test Plan:
- Reset, enable=1; ship0 horizontal at col0/row0, confirm -> mapa0=mapa1=mapa2=7'b0000001, LED_G=1, navio_atual=1.
- Ship1 horizontal at col4/row5 (overflows col), confirm -> LED_R=1, valido=0, map unchanged, navio_atual=1; hold confirmar high 5 cycles -> only one rejection, no state change.
- Ship1 vertical at col1/row0 (overlaps ship0) -> rejected with LED_R=1; then vertical at col4/row5, confirm -> mapa4=7'b1100000, LED_G=1.
- Ship2 at col3/row3, confirm -> mapa3=7'b0001000, mapa_pronto=1, navio_atual=3; a further confirm at col0/row6 -> no change.
- Mid-placement (after ship0), enable=0 for one cycle -> all mapa*=0, state OCIOSO. enable=1 -> placement restarts at ship0. Same test with reset=1 during PRONTO -> all outputs 0.
- coordColuna=5, size-1 ship (drive placement to ship2) -> valido=0, previa unchanged from mapa, and confirm is rejected.

Source files
------------

// File: rtl/posicionador_de_navios_pkg.sv
// rtl/posicionador_de_navios_pkg.sv - shared grid geometry, fleet sizes and FSM states
package posicionador_de_navios_pkg;

    localparam int NUM_COLUNAS = 5;
    localparam int NUM_LINHAS  = 7;
    localparam int NUM_CELULAS = NUM_COLUNAS * NUM_LINHAS;
    localparam int NUM_NAVIOS  = 3;
    localparam int TAM_MAXIMO  = 3;

    localparam int TAM_PADRAO0 = 3;
    localparam int TAM_PADRAO1 = 2;
    localparam int TAM_PADRAO2 = 1;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        POSICIONA = 2'd1,
        PRONTO    = 2'd2
    } estado_t;

endpackage

// File: rtl/posicionador_de_navios_gerador_mascara_navio.sv
// rtl/posicionador_de_navios_gerador_mascara_navio.sv - ghost ship mask and bounds check
module gerador_mascara_navio
    import posicionador_de_navios_pkg::*;
(
    input  logic [2:0]             col,
    input  logic [2:0]             row,
    input  logic                   orientacao,
    input  logic [1:0]             tam,
    output logic [NUM_CELULAS-1:0] mascara,
    output logic                   fora_limites
);

    logic [3:0] ext;
    logic [3:0] fim_col;
    logic [3:0] fim_row;

    // Cells past the grid edge are dropped rather than wrapped into the next column/row.
    always_comb begin
        int c;
        int r;
        mascara = '0;
        c = 0;
        r = 0;
        for (int i = 0; i < TAM_MAXIMO; i++) begin
            if (i < int'(tam)) begin
                c = int'(col) + (orientacao ? 0 : i);
                r = int'(row) + (orientacao ? i : 0);
                if (c < NUM_COLUNAS && r < NUM_LINHAS) begin
                    mascara[c*NUM_LINHAS + r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ext          = (tam == 2'd0) ? 4'd0 : ({2'b00, tam} - 4'd1);
        fim_col      = {1'b0, col} + (orientacao ? 4'd0 : ext);
        fim_row      = {1'b0, row} + (orientacao ? ext : 4'd0);
        fora_limites = ({1'b0, col} > 4'(NUM_COLUNAS - 1)) ||
                       ({1'b0, row} > 4'(NUM_LINHAS - 1))  ||
                       (fim_col > 4'(NUM_COLUNAS - 1))     ||
                       (fim_row > 4'(NUM_LINHAS - 1));
    end

endmodule

// File: rtl/posicionador_de_navios.sv
// rtl/posicionador_de_navios.sv - fleet placement FSM building the battleship map
module posicionador_de_navios
    import posicionador_de_navios_pkg::*;
#(
    parameter int TAM_NAVIO0 = TAM_PADRAO0,
    parameter int TAM_NAVIO1 = TAM_PADRAO1,
    parameter int TAM_NAVIO2 = TAM_PADRAO2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] coordColuna,
    input  logic [2:0] coordLinha,
    input  logic       orientacao,
    input  logic       confirmar,
    output logic [6:0] mapa0,
    output logic [6:0] mapa1,
    output logic [6:0] mapa2,
    output logic [6:0] mapa3,
    output logic [6:0] mapa4,
    output logic [6:0] previa0,
    output logic [6:0] previa1,
    output logic [6:0] previa2,
    output logic [6:0] previa3,
    output logic [6:0] previa4,
    output logic [1:0] navio_atual,
    output logic       valido,
    output logic       LED_R,
    output logic       LED_G,
    output logic       mapa_pronto
);

    estado_t                estado;
    logic                   conf_prev;
    logic                   pulso;
    logic [NUM_CELULAS-1:0] mapa;
    logic [NUM_CELULAS-1:0] mascara;
    logic [NUM_CELULAS-1:0] previa;
    logic [1:0]             tam_atual;
    logic                   fora_limites;

    assign pulso = confirmar & ~conf_prev;

    always_comb begin
        case (navio_atual)
            2'd0:    tam_atual = TAM_NAVIO0[1:0];
            2'd1:    tam_atual = TAM_NAVIO1[1:0];
            2'd2:    tam_atual = TAM_NAVIO2[1:0];
            default: tam_atual = 2'd0;
        endcase
    end

    gerador_mascara_navio u_mascara (
        .col          (coordColuna),
        .row          (coordLinha),
        .orientacao   (orientacao),
        .tam          (tam_atual),
        .mascara      (mascara),
        .fora_limites (fora_limites)
    );

    assign valido = (estado == POSICIONA) && !fora_limites && !(|(mascara & mapa));

    // The ghost is only shown while a ship is being placed; idle shows nothing.
    always_comb begin
        previa = '0;
        if (estado == POSICIONA) begin
            previa = mapa | mascara;
        end else if (estado == PRONTO) begin
            previa = mapa;
        end
    end

    assign mapa0   = mapa[0*NUM_LINHAS +: NUM_LINHAS];
    assign mapa1   = mapa[1*NUM_LINHAS +: NUM_LINHAS];
    assign mapa2   = mapa[2*NUM_LINHAS +: NUM_LINHAS];
    assign mapa3   = mapa[3*NUM_LINHAS +: NUM_LINHAS];
    assign mapa4   = mapa[4*NUM_LINHAS +: NUM_LINHAS];
    assign previa0 = previa[0*NUM_LINHAS +: NUM_LINHAS];
    assign previa1 = previa[1*NUM_LINHAS +: NUM_LINHAS];
    assign previa2 = previa[2*NUM_LINHAS +: NUM_LINHAS];
    assign previa3 = previa[3*NUM_LINHAS +: NUM_LINHAS];
    assign previa4 = previa[4*NUM_LINHAS +: NUM_LINHAS];

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= OCIOSO;
            conf_prev   <= 1'b0;
            mapa        <= '0;
            navio_atual <= 2'd0;
            LED_R       <= 1'b0;
            LED_G       <= 1'b0;
            mapa_pronto <= 1'b0;
        end else begin
            conf_prev <= confirmar;
            // Dropping enable abandons the session even if a confirm arrives on the same edge.
            if (!enable) begin
                estado      <= OCIOSO;
                mapa        <= '0;
                navio_atual <= 2'd0;
                LED_R       <= 1'b0;
                LED_G       <= 1'b0;
                mapa_pronto <= 1'b0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        estado      <= POSICIONA;
                        navio_atual <= 2'd0;
                    end
                    POSICIONA: begin
                        if (pulso) begin
                            if (valido) begin
                                mapa        <= mapa | mascara;
                                navio_atual <= navio_atual + 2'd1;
                                LED_G       <= 1'b1;
                                LED_R       <= 1'b0;
                                if (navio_atual == 2'(NUM_NAVIOS - 1)) begin
                                    estado      <= PRONTO;
                                    mapa_pronto <= 1'b1;
                                end
                            end else begin
                                LED_R <= 1'b1;
                                LED_G <= 1'b0;
                            end
                        end
                    end
                    PRONTO: begin
                        estado <= PRONTO;
                    end
                    default: begin
                        estado <= OCIOSO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_posicionador_de_navios.sv
// tb/tb_posicionador_de_navios.sv - randomized bench against a cell-level fleet model
module tb_posicionador_de_navios;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [2:0] coordColuna;
    logic [2:0] coordLinha;
    logic       orientacao;
    logic       confirmar;
    logic [6:0] mapa   [5];
    logic [6:0] previa [5];
    logic [1:0] navio_atual;
    logic       valido;
    logic       LED_R;
    logic       LED_G;
    logic       mapa_pronto;

    posicionador_de_navios dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .coordColuna (coordColuna),
        .coordLinha  (coordLinha),
        .orientacao  (orientacao),
        .confirmar   (confirmar),
        .mapa0       (mapa[0]),
        .mapa1       (mapa[1]),
        .mapa2       (mapa[2]),
        .mapa3       (mapa[3]),
        .mapa4       (mapa[4]),
        .previa0     (previa[0]),
        .previa1     (previa[1]),
        .previa2     (previa[2]),
        .previa3     (previa[3]),
        .previa4     (previa[4]),
        .navio_atual (navio_atual),
        .valido      (valido),
        .LED_R       (LED_R),
        .LED_G       (LED_G),
        .mapa_pronto (mapa_pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic verifica(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: occupied cells, session phase (0 idle, 1 placing, 2 done), ship count, LEDs.
    bit ocupado [5][7];
    int fase;
    int navios;
    int m_r, m_g;
    int m_conf_prev;
    int tams [3] = '{3, 2, 1};

    function automatic int tam_ghost();
        return (fase == 1) ? tams[navios] : 0;
    endfunction

    function automatic bit no_fantasma(int c, int r, int col, int lin, int ori);
        for (int i = 0; i < tam_ghost(); i++) begin
            if (ori != 0 && c == col && r == lin + i) return 1'b1;
            if (ori == 0 && r == lin && c == col + i) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int valido_modelo(int col, int lin, int ori);
        int n;
        n = tam_ghost();
        if (fase != 1) return 0;
        if (col > 4 || lin > 6) return 0;
        if (ori != 0 && lin + n - 1 > 6) return 0;
        if (ori == 0 && col + n - 1 > 4) return 0;
        for (int i = 0; i < n; i++) begin
            if (ori != 0 && ocupado[col][lin + i]) return 0;
            if (ori == 0 && ocupado[col + i][lin]) return 0;
        end
        return 1;
    endfunction

    function automatic int coluna_mapa(int c);
        int v = 0;
        for (int r = 0; r < 7; r++) if (ocupado[c][r]) v |= (1 << r);
        return v;
    endfunction

    function automatic int coluna_previa(int c, int col, int lin, int ori);
        int v = 0;
        if (fase == 0) return 0;
        for (int r = 0; r < 7; r++)
            if (ocupado[c][r] || no_fantasma(c, r, col, lin, ori)) v |= (1 << r);
        return v;
    endfunction

    task automatic limpa_modelo();
        for (int c = 0; c < 5; c++) for (int r = 0; r < 7; r++) ocupado[c][r] = 1'b0;
        fase = 0; navios = 0; m_r = 0; m_g = 0;
    endtask

    task automatic atualiza_modelo(int rst, int en, int col, int lin, int ori, int conf);
        int pulso;
        int ok;
        if (rst != 0) begin
            limpa_modelo();
            m_conf_prev = 0;
            return;
        end
        pulso = (conf != 0 && m_conf_prev == 0) ? 1 : 0;
        ok = valido_modelo(col, lin, ori);
        m_conf_prev = conf;
        if (en == 0) begin
            limpa_modelo();
        end else if (fase == 0) begin
            fase = 1; navios = 0;
        end else if (fase == 1 && pulso != 0) begin
            if (ok != 0) begin
                for (int c = 0; c < 5; c++)
                    for (int r = 0; r < 7; r++)
                        if (no_fantasma(c, r, col, lin, ori)) ocupado[c][r] = 1'b1;
                navios++;
                m_g = 1; m_r = 0;
                if (navios == 3) fase = 2;
            end else begin
                m_r = 1; m_g = 0;
            end
        end
    endtask

    task automatic ciclo(int rst, int en, int col, int lin, int ori, int conf);
        reset = rst[0]; enable = en[0];
        coordColuna = col[2:0]; coordLinha = lin[2:0];
        orientacao = ori[0]; confirmar = conf[0];
        #3;
        verifica("valido", int'(valido), valido_modelo(col, lin, ori));
        for (int c = 0; c < 5; c++)
            verifica($sformatf("previa%0d", c), int'(previa[c]), coluna_previa(c, col, lin, ori));
        @(posedge clock);
        atualiza_modelo(rst, en, col, lin, ori, conf);
        #1;
        for (int c = 0; c < 5; c++)
            verifica($sformatf("mapa%0d", c), int'(mapa[c]), coluna_mapa(c));
        verifica("navio_atual", int'(navio_atual), navios);
        verifica("LED_R", int'(LED_R), m_r);
        verifica("LED_G", int'(LED_G), m_g);
        verifica("mapa_pronto", int'(mapa_pronto), (fase == 2) ? 1 : 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; coordColuna = '0; coordLinha = '0;
        orientacao = 1'b0; confirmar = 1'b0;
        @(posedge clock);
        #1;
        atualiza_modelo(1, 0, 0, 0, 0, 0);

        ciclo(1, 1, 0, 0, 0, 0);
        verifica("reset_mapa0", int'(mapa[0]), 0);
        verifica("reset_pronto", int'(mapa_pronto), 0);
        ciclo(0, 1, 0, 0, 0, 0);
        ciclo(0, 1, 0, 0, 0, 1);
        verifica("ship0_mapa0", int'(mapa[0]), 7'b0000001);
        verifica("ship0_mapa2", int'(mapa[2]), 7'b0000001);
        verifica("ship0_led_g", int'(LED_G), 1);
        ciclo(0, 1, 4, 5, 0, 0);
        verifica("overflow_valido", int'(valido), 0);
        for (int i = 0; i < 5; i++) ciclo(0, 1, 4, 5, 0, 1);
        verifica("overflow_led_r", int'(LED_R), 1);
        verifica("overflow_navio", int'(navio_atual), 1);
        ciclo(0, 1, 1, 0, 1, 0);
        ciclo(0, 1, 1, 0, 1, 1);
        verifica("overlap_led_r", int'(LED_R), 1);
        ciclo(0, 1, 4, 5, 1, 0);
        ciclo(0, 1, 4, 5, 1, 1);
        verifica("ship1_mapa4", int'(mapa[4]), 7'b1100000);
        ciclo(0, 1, 5, 3, 0, 0);
        verifica("col5_valido", int'(valido), 0);
        verifica("col5_previa4", int'(previa[4]), 7'b1100000);
        ciclo(0, 1, 5, 3, 0, 1);
        verifica("col5_led_r", int'(LED_R), 1);
        ciclo(0, 1, 3, 3, 0, 0);
        ciclo(0, 1, 3, 3, 0, 1);
        verifica("ship2_mapa3", int'(mapa[3]), 7'b0001000);
        verifica("ship2_pronto", int'(mapa_pronto), 1);
        verifica("ship2_navio", int'(navio_atual), 3);
        ciclo(0, 1, 0, 6, 0, 0);
        ciclo(0, 1, 0, 6, 0, 1);
        verifica("pronto_mapa0", int'(mapa[0]), 7'b0000001);
        ciclo(1, 1, 0, 0, 0, 0);
        verifica("pronto_reset_mapa4", int'(mapa[4]), 0);
        ciclo(0, 1, 0, 0, 0, 0);
        ciclo(0, 1, 2, 2, 1, 1);
        ciclo(0, 0, 2, 2, 1, 0);
        verifica("enable_drop_mapa2", int'(mapa[2]), 0);
        ciclo(0, 1, 0, 0, 0, 0);
        ciclo(0, 1, 0, 0, 0, 0);
        verifica("restart_navio", int'(navio_atual), 0);

        for (int n = 0; n < 3000; n++) begin
            ciclo(($urandom_range(0, 199) == 0) ? 1 : 0,
                  ($urandom_range(0, 59) == 0) ? 0 : 1,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
